// File: rtl/pwm_modulator.sv
// pwm_modulator: edge-aligned PWM with a double-buffered duty command; define PWM_COMPLEMENT_EN for a dead-time complementary output
module pwm_modulator #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8,
  parameter int PERIOD    = 200,
  parameter int DUTY_MIN  = 0,
  parameter int DUTY_MAX  = 180,
  parameter int DEADTIME  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] dutyIn,
  input  logic             dutyValid,
  output logic             pwmOut,
  output logic             pwmOutN,
  output logic             periodStart,
  output logic             dutyClamped
);
  // duty values need one extra bit so that a full-period duty (PERIOD = 2^CNT_WIDTH) is representable
  localparam int DW = CNT_WIDTH + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next, raw;
  logic [DW-1:0] duty_active, duty_active_next, duty_pending, duty_clamp;
  logic clamp_lo, clamp_hi, last, load, active, pwm_next, start_next;
  if (CNT_WIDTH > WIDTH || PERIOD < 2 || PERIOD > 2 ** CNT_WIDTH || DUTY_MIN < 0 ||
      DUTY_MIN > DUTY_MAX || DUTY_MAX > PERIOD || DEADTIME < 0) begin : g_bad_params
    $error("pwm_modulator: inconsistent parameters");
  end
  if (WIDTH > CNT_WIDTH) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^dutyIn[WIDTH-CNT_WIDTH-1:0];
  end
  assign raw = dutyIn[WIDTH-1 -: CNT_WIDTH];
  assign clamp_lo = int'({1'b0, raw}) < DUTY_MIN;
  assign clamp_hi = int'({1'b0, raw}) > DUTY_MAX;
  assign duty_clamp = clamp_lo ? DW'(DUTY_MIN) : clamp_hi ? DW'(DUTY_MAX) : {1'b0, raw};
  // next state, period counter, boundary duty load (same-cycle strobe bypasses the pending buffer) and output decode
  always_comb begin
    state_next = enable ? RUN : IDLE;
    active = state == RUN & enable;
    last = cnt == CNT_WIDTH'(PERIOD - 1);
    load = enable & (state == IDLE | last);
    cnt_next = active & !last ? cnt + CNT_WIDTH'(1) : '0;
    duty_active_next = load ? (dutyValid ? duty_clamp : duty_pending) : duty_active;
    start_next = active & cnt == '0;
    pwm_next = active & ({1'b0, cnt} < duty_active);
  end
  // state, counter, duty buffers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      duty_active <= '0;
      duty_pending <= DW'(DUTY_MIN);
      pwmOut <= 1'b0;
      periodStart <= 1'b0;
      dutyClamped <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
      duty_active <= duty_active_next;
      pwmOut <= pwm_next;
      periodStart <= start_next;
      if (dutyValid) begin
        duty_pending <= duty_clamp;
        dutyClamped <= clamp_lo | clamp_hi;
      end
    end
  end
`ifdef PWM_COMPLEMENT_EN
  logic pwmn_next;
  assign pwmn_next = active && int'({1'b0, cnt}) >= int'(duty_active) + DEADTIME &&
                     int'({1'b0, cnt}) < PERIOD - DEADTIME;
  // complementary gate: low for DEADTIME cycles on either side of the main gate, wrap included
  always_ff @(posedge clk) begin
    pwmOutN <= reset ? 1'b0 : pwmn_next;
  end
`else
  assign pwmOutN = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_modulator.sv
// tb_pwm_modulator: directed scenarios plus randomized run against a period-level reference model
`timescale 1ns/1ps
module tb_pwm_modulator;
  localparam int WIDTH = 16, CW = 8, PERIOD = 200, DMIN = 0, DT = 4;
`ifdef PWM_COMPLEMENT_EN
  localparam int DMAX = 200, COMP = 1;
`else
  localparam int DMAX = 180, COMP = 0;
`endif
  logic clk = 0, reset = 1, enable = 0, dutyValid = 0;
  logic [WIDTH-1:0] dutyIn = '0;
  logic pwmOut, pwmOutN, periodStart, dutyClamped;
  int nchk = 0, nerr = 0;
  int m_k = -1, m_nk = 0, m_act = 0, m_pend = DMIN, m_raw, m_cl;
  bit m_run = 0;
  logic e_pwm = 0, e_pwmn = 0, e_ps = 0, e_cl = 0;
  int p_hi, p_flow, p_hin, p_nfirst, p_both, p_ps, p_ps0;
  bit ok;

  always #5 clk = ~clk;

  pwm_modulator #(.WIDTH(WIDTH), .CNT_WIDTH(CW), .PERIOD(PERIOD), .DUTY_MIN(DMIN),
                  .DUTY_MAX(DMAX), .DEADTIME(DT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dutyIn(dutyIn), .dutyValid(dutyValid),
    .pwmOut(pwmOut), .pwmOutN(pwmOutN), .periodStart(periodStart), .dutyClamped(dutyClamped));

  // reference: m_k is the period index shown on the outputs after this edge (-1 = idle)
  always @(posedge clk) begin
    m_raw = int'(dutyIn >> (WIDTH - CW));
    m_cl = m_raw < DMIN ? DMIN : (m_raw > DMAX ? DMAX : m_raw);
    e_pwm = 0; e_pwmn = 0; e_ps = 0;
    if (reset) begin
      m_run = 0; m_k = -1; m_act = 0; m_pend = DMIN; e_cl = 0;
    end else begin
      if (!enable) begin
        m_run = 0; m_k = -1;
      end else if (!m_run) begin
        m_run = 1; m_k = -1; m_nk = 0; m_act = dutyValid ? m_cl : m_pend;
      end else begin
        m_k = m_nk;
        e_pwm = m_k < m_act;
        e_pwmn = COMP == 1 && m_k >= m_act + DT && m_k < PERIOD - DT;
        e_ps = m_k == 0;
        if (m_k == PERIOD - 1) m_act = dutyValid ? m_cl : m_pend;
        m_nk = (m_k + 1) % PERIOD;
      end
      if (dutyValid) begin m_pend = m_cl; e_cl = m_raw != m_cl; end
    end
  end

  task automatic wait_k(input int t);
    ok = 0;
    for (int i = 0; i < 3 * PERIOD && !ok; i++) begin @(negedge clk); ok = m_k == t; end
    if (!ok) begin nerr++; $display("FAIL sync: k=%0d never reached", t); end
  endtask

  // measures one period starting at the current negedge; optional duty strobe sampled at cnt==sk+1
  task automatic run_period(input int sk, input logic [WIDTH-1:0] sd);
    p_hi = 0; p_flow = PERIOD; p_hin = 0; p_nfirst = PERIOD; p_both = 0; p_ps = 0; p_ps0 = int'(periodStart);
    for (int i = 0; i < PERIOD; i++) begin
      if (pwmOut) p_hi++; else if (p_flow == PERIOD) p_flow = i;
      if (pwmOutN) begin p_hin++; if (p_nfirst == PERIOD) p_nfirst = i; end
      if (pwmOut && pwmOutN) p_both++;
      if (periodStart) p_ps++;
      if (i == sk) begin dutyIn = sd; dutyValid = 1; end
      @(negedge clk);
      dutyValid = 0;
    end
  endtask

  task automatic test_reset;
    int ps = 0, hi = 0;
    reset = 1; enable = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nchk++;
      if ({pwmOut, pwmOutN, periodStart, dutyClamped} !== 4'b0) begin
        nerr++; $display("FAIL reset_outputs: got %b exp 0000", {pwmOut, pwmOutN, periodStart, dutyClamped});
      end
    end
    reset = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (periodStart) ps++;
      if (pwmOut) hi++;
      if (i == 1) begin
        nchk++;
        if (periodStart !== 1'b1) begin nerr++; $display("FAIL first_start: got %b exp 1", periodStart); end
      end
      nchk++;
      if ({pwmOut, pwmOutN, periodStart, dutyClamped} !== {e_pwm, e_pwmn, e_ps, e_cl}) begin
        nerr++; $display("FAIL reset_model cyc %0d: got %b exp %b", i,
          {pwmOut, pwmOutN, periodStart, dutyClamped}, {e_pwm, e_pwmn, e_ps, e_cl});
      end
    end
    nchk++; if (ps !== 2) begin nerr++; $display("FAIL start_count: got %0d exp 2", ps); end
    nchk++; if (hi !== 0) begin nerr++; $display("FAIL zero_duty_high: got %0d exp 0", hi); end
  endtask

  task automatic test_duty;
    wait_k(0);
    run_period(50, 16'h6400);
    nchk++; if (p_hi !== 0) begin nerr++; $display("FAIL duty_same_period: got %0d exp 0", p_hi); end
    nchk++; if (p_ps !== 1 || p_ps0 !== 1) begin nerr++; $display("FAIL duty_start: got %0d/%0d exp 1/1", p_ps, p_ps0); end
    nchk++; if (dutyClamped !== 1'b0) begin nerr++; $display("FAIL duty_clamped: got %b exp 0", dutyClamped); end
    run_period(-1, '0);
    nchk++; if (p_hi !== 100) begin nerr++; $display("FAIL duty_high: got %0d exp 100", p_hi); end
    nchk++; if (p_flow !== 100) begin nerr++; $display("FAIL duty_shape: first low %0d exp 100", p_flow); end
  endtask

  task automatic test_clamp;
    run_period(60, 16'hFF00);
    nchk++; if (p_hi !== 100) begin nerr++; $display("FAIL clamp_prev: got %0d exp 100", p_hi); end
    nchk++; if (dutyClamped !== 1'b1) begin nerr++; $display("FAIL clamp_flag: got %b exp 1", dutyClamped); end
    run_period(60, 16'h0A00);
    nchk++; if (p_hi !== DMAX || p_flow !== DMAX) begin nerr++; $display("FAIL clamp_high: got %0d/%0d exp %0d", p_hi, p_flow, DMAX); end
    nchk++; if (dutyClamped !== 1'b0) begin nerr++; $display("FAIL clamp_clear: got %b exp 0", dutyClamped); end
    run_period(-1, '0);
    nchk++; if (p_hi !== 10) begin nerr++; $display("FAIL small_duty: got %0d exp 10", p_hi); end
  endtask

  task automatic test_bypass;
    wait_k(PERIOD - 2);
    dutyIn = 16'h3200; dutyValid = 1;
    @(negedge clk);
    dutyIn = 16'h7800;
    @(negedge clk);
    dutyValid = 0;
    run_period(-1, '0);
    nchk++; if (p_hi !== 50 || p_ps0 !== 1) begin nerr++; $display("FAIL bypass: got %0d start %0d exp 50 start 1", p_hi, p_ps0); end
    run_period(-1, '0);
    nchk++; if (p_hi !== 120) begin nerr++; $display("FAIL back_to_back: got %0d exp 120", p_hi); end
  endtask

  task automatic test_enable;
    int idle_hi = 0;
    run_period(60, 16'h6400);
    repeat (40) @(negedge clk);
    nchk++; if (pwmOut !== 1'b1) begin nerr++; $display("FAIL pre_drop: got %b exp 1", pwmOut); end
    enable = 0;
    @(negedge clk);
    nchk++; if (pwmOut !== 1'b0 || periodStart !== 1'b0) begin nerr++; $display("FAIL drop: got %b%b exp 00", pwmOut, periodStart); end
    for (int i = 0; i < 30; i++) begin
      if (i == 10) begin dutyIn = 16'h1E00; dutyValid = 1; end
      @(negedge clk);
      dutyValid = 0;
      if (pwmOut || pwmOutN || periodStart) idle_hi++;
    end
    nchk++; if (idle_hi !== 0) begin nerr++; $display("FAIL idle_outputs: got %0d active cycles exp 0", idle_hi); end
    enable = 1;
    @(negedge clk);
    nchk++; if (periodStart !== 1'b0) begin nerr++; $display("FAIL reenable_early: got %b exp 0", periodStart); end
    @(negedge clk);
    nchk++; if (periodStart !== 1'b1) begin nerr++; $display("FAIL reenable_start: got %b exp 1", periodStart); end
    run_period(-1, '0);
    nchk++; if (p_hi !== 30 || p_ps !== 1) begin nerr++; $display("FAIL reenable_duty: got %0d/%0d exp 30/1", p_hi, p_ps); end
  endtask

  task automatic test_complement;
    run_period(10, 16'h6400);
    run_period(10, 16'hC400);
    nchk++; if (p_hi !== 100) begin nerr++; $display("FAIL comp_main: got %0d exp 100", p_hi); end
    nchk++; if (p_hin !== (COMP == 1 ? 92 : 0)) begin nerr++; $display("FAIL comp_high: got %0d exp %0d", p_hin, COMP == 1 ? 92 : 0); end
    nchk++; if (p_nfirst !== (COMP == 1 ? 104 : PERIOD)) begin nerr++; $display("FAIL comp_first: got %0d exp %0d", p_nfirst, COMP == 1 ? 104 : PERIOD); end
    nchk++; if (p_both !== 0) begin nerr++; $display("FAIL comp_overlap: got %0d exp 0", p_both); end
    nchk++; if (dutyClamped !== (196 > DMAX)) begin nerr++; $display("FAIL comp_clamp: got %b exp %b", dutyClamped, 196 > DMAX); end
    run_period(-1, '0);
    nchk++; if (p_hi !== (196 > DMAX ? DMAX : 196)) begin nerr++; $display("FAIL wide_main: got %0d", p_hi); end
    nchk++; if (p_hin !== 0) begin nerr++; $display("FAIL wide_comp: got %0d exp 0", p_hin); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 6000; i++) begin
      dutyValid = ($urandom % 16) == 0;
      dutyIn = ($urandom % 8) == 0 ? '0 : WIDTH'($urandom);
      if (($urandom % 400) == 0) enable = !enable;
      reset = ($urandom % 1500) == 0;
      @(negedge clk);
      nchk++;
      if ({pwmOut, pwmOutN, periodStart, dutyClamped} !== {e_pwm, e_pwmn, e_ps, e_cl}) begin
        nerr++; $display("FAIL random cyc %0d: got %b exp %b", i,
          {pwmOut, pwmOutN, periodStart, dutyClamped}, {e_pwm, e_pwmn, e_ps, e_cl});
      end
      nchk++;
      if ((pwmOut & pwmOutN) !== 1'b0) begin nerr++; $display("FAIL random_overlap cyc %0d: both gates high", i); end
    end
    reset = 0; dutyValid = 0;
  endtask

  initial begin
    test_reset;
    test_duty;
    test_clamp;
    test_bypass;
    test_enable;
    test_complement;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
